// File: rtl/mult_div_unit.sv
`timescale 1ns/1ps
// mult_div_unit
// Iterative multiply/divide unit for the MIPS execute stage. It owns the
// HI/LO architectural registers and serves MULT, MULTU, DIV, DIVU, MTHI
// and MTLO. A multiply or divide takes WIDTH+1 clock edges from accept to
// result. Control stalls the pipeline while Busy is high.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   Start        request a multiply/divide (sampled only in IDLE)
//   MDOperation  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   HIWrite      MTHI: load A into HI (IDLE, no Start)
//   LOWrite      MTLO: load A into LO (IDLE, no Start)
//   A, B         operand buses shared with the ALU
//   Busy         operation in progress
//   Done         one-cycle completion pulse
//   DivByZero    the last divide had a zero divisor
//   HI, LO       high product / remainder, low product / quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOperation,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               zero_div_q, zero_div_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes; the unsigned variants (MDOperation[0]=1) never negate.
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_signed = ~MDOperation[0];
  assign a_neg     = op_signed & A[WIDTH-1];
  assign b_neg     = op_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? (~A + 1'b1) : A;
  assign b_mag     = b_neg ? (~B + 1'b1) : B;

  // Multiply step: the upper half accumulates the multiplicand when the
  // current multiplier bit (acc[0]) is set, then the whole accumulator
  // shifts right with the carry coming in at the top.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: the partial remainder lives in the upper half
  // and the dividend shifts out of the lower half while quotient bits
  // shift in. The remainder stays below the divisor, so one extra bit
  // is enough to hold the shifted value.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                      acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

  // Sign-corrected results for the FIX state.
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  assign prod_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quot_fixed = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fixed  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    zero_div_d = zero_div_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          // Start takes priority over MTHI/MTLO in the same cycle.
          is_div_d   = MDOperation[1];
          neg_d      = a_neg ^ b_neg;
          rem_neg_d  = a_neg;
          opnd_d     = MDOperation[1] ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (MDOperation[1] ? a_mag : b_mag)};
          cnt_d      = '0;
          dbz_d      = 1'b0;
          zero_div_d = MDOperation[1] && (B == '0);
          state_d    = (MDOperation[1] && (B == '0)) ? FIX : RUN;
        end else begin
          if (HIWrite) hi_d = A;
          if (LOWrite) lo_d = A;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_div_q) begin
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = quot_fixed;
          hi_d = rem_fixed;
        end else begin
          hi_d = prod_fixed[2*WIDTH-1:WIDTH];
          lo_d = prod_fixed[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      zero_div_q <= 1'b0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      zero_div_q <= zero_div_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the execute stage of the MIPS datapath. It runs beside the single-cycle ALU and takes the same A/B operand buses. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the HI/LO architectural registers that MFHI/MFLO select into writeback next to ALUResult. Operations take multiple cycles; control stalls the pipeline on Busy.

## Interface
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Start  in  1  request a multiply/divide; sampled only in IDLE
- MDOperation  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- HIWrite  in  1  MTHI: load A into HI; honoured only in IDLE without Start
- LOWrite  in  1  MTLO: load A into LO; honoured only in IDLE without Start
- A  in  WIDTH  multiplicand / dividend / MTHI-MTLO data
- B  in  WIDTH  multiplier / divisor
- Busy  out  1  operation in progress; control stalls while high
- Done  out  1  one-cycle pulse when a multiply/divide completes
- DivByZero  out  1  the last divide had B==0; valid from Done until the next accepted Start
- HI  out  WIDTH  high product / remainder
- LO  out  WIDTH  low product / quotient

## Operation
- States: IDLE, RUN, FIX.
- IDLE with Start=1: latch the operation and operand magnitudes. Signed ops take two's-complement absolute values and record the result signs. Clear DivByZero, set counter=0, Busy=1, go to RUN.
- Divide-by-zero exception: DIV/DIVU with B==0 skips RUN and goes straight to FIX. FIX leaves HI/LO unchanged and sets DivByZero=1.
- RUN, multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle.
- RUN, divide: restoring divide, one quotient bit per cycle.
- RUN ends after WIDTH iterations (counter wraps WIDTH-1 -> exit) and moves to FIX.
- FIX: apply sign correction and write HI/LO. Busy=0, Done=1, go to IDLE.
- Signed multiply: the 64-bit product is negated when operand signs differ. HI = upper word, LO = lower word.
- Divide: quotient truncates toward zero and goes to LO. Remainder takes the dividend's sign and goes to HI.
- Divide overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No flag is raised.
- Start while Busy: ignored. HIWrite/LOWrite while Busy: ignored.
- Start together with HIWrite/LOWrite in IDLE: Start wins and the writes are dropped.
- HIWrite and LOWrite together in IDLE: both registers load A.
- Operands are latched at accept. Changes on A/B during RUN have no effect.

## Timing
- Reset (asynchronous, any state): state=IDLE, HI=0, LO=0, Busy=0, Done=0, DivByZero=0. An operation in progress is aborted and no Done is produced.
- Accept edge E0 (IDLE, Start=1): Busy is high from E0.
- Normal operation: iterations occur on edges E1..E32. At E33, HI/LO update, Busy falls and Done rises, so the result is readable in the cycle after E33. Latency is WIDTH+1 edges.
- Divide by zero: FIX at E1, so Done=1, DivByZero=1 and Busy=0 after E1.
- Done lasts exactly one cycle. A Start presented during the Done cycle is accepted (back-to-back, no idle gap).
- MTHI/MTLO: HI/LO update at the sampling edge. No Busy, no Done.
- HI/LO hold their values in all other cycles, including throughout RUN.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Done exactly 33 edges after accept; Busy high for those 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Back-to-back MULT started in the Done cycle with A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7, B=2 -> LO=3, HI=1. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=5, B=0 with prior HI=0x11, LO=0x22 -> Done and DivByZero after E1, HI/LO unchanged. The next accepted Start clears DivByZero.
- HIWrite/LOWrite: in IDLE, HIWrite with A=0xDEADBEEF -> HI=0xDEADBEEF. During RUN, LOWrite and Start are ignored (LO and the running result unaffected). Start+HIWrite together in IDLE -> only the multiply/divide occurs.
- Assert reset at iteration 10 of a MULTU -> HI=LO=0, Busy=0 immediately, no Done pulse. A fresh Start after reset completes correctly.
